// File: rtl/gshare_btb_predictor.sv
// Fetch-stage gshare direction predictor with a direct-mapped BTB and a speculative, checkpointed GHR.
// Optional statistics counters are enabled by defining GSHARE_STATS_EN.
module gshare_btb_predictor #(
    parameter int GBIT    = 10,
    parameter int BTB_IDX = 6,
    parameter int TAG_W   = 12
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_lookup_valid,
    input  logic [31:0]     i_lookup_pc,
    output logic            o_ready,
    output logic            o_pred_taken,
    output logic [31:0]     o_pred_target,
    output logic            o_btb_hit,
    output logic [GBIT-1:0] o_pred_ghr,
    input  logic            i_upd_valid,
    input  logic [31:0]     i_upd_pc,
    input  logic            i_upd_is_cond,
    input  logic            i_upd_taken,
    input  logic [31:0]     i_upd_target,
    input  logic [GBIT-1:0] i_upd_ghr,
    input  logic            i_upd_mispredict
`ifdef GSHARE_STATS_EN
    ,
    output logic [31:0]     o_lookup_cnt,
    output logic [31:0]     o_mispred_cnt
`endif
);

    localparam int PHT_DEPTH = 1 << GBIT;
    localparam int BTB_DEPTH = 1 << BTB_IDX;
    localparam logic [GBIT-1:0] INIT_LAST = '1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t               state_q, state_d;
    logic [GBIT-1:0]      init_ptr_q, init_ptr_d;
    logic [GBIT-1:0]      ghr_q, ghr_d;
    logic [BTB_DEPTH-1:0] btb_valid_q, btb_valid_d;

    logic [1:0]       pht_mem     [PHT_DEPTH];
    logic [TAG_W-1:0] btb_tag_mem [BTB_DEPTH];
    logic [31:0]      btb_tgt_mem [BTB_DEPTH];
    logic             btb_cond_mem[BTB_DEPTH];

    logic                ready;
    logic [GBIT-1:0]     lk_pidx;
    logic [BTB_IDX-1:0]  lk_bidx;
    logic [TAG_W-1:0]    lk_tag;
    logic                lk_hit;
    logic                lk_taken;
    logic                lk_cond;
    logic [31:0]         lk_pc_plus4;

    logic                upd_en;
    logic [GBIT-1:0]     upd_pidx;
    logic [BTB_IDX-1:0]  upd_bidx;
    logic [TAG_W-1:0]    upd_tag;
    logic [1:0]          upd_ctr;
    logic [1:0]          upd_ctr_next;

    logic                pht_we;
    logic [GBIT-1:0]     pht_waddr;
    logic [1:0]          pht_wdata;
    logic                btb_we;

    logic                unused_upd_pc;

    assign ready = (state_q == ST_RUN);
    assign unused_upd_pc = ^i_upd_pc;

    // Init sequencer: sweeps every PHT slot to weakly-taken, then predictions go live.
    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        if (state_q == ST_INIT) begin
            init_ptr_d = init_ptr_q + GBIT'(1);
            if (init_ptr_q == INIT_LAST) begin
                state_d = ST_RUN;
            end
        end
    end

    // Lookup path is purely combinational so fetch gets a prediction in the same cycle.
    always_comb begin
        lk_pidx     = i_lookup_pc[GBIT+1:2] ^ ghr_q;
        lk_bidx     = i_lookup_pc[BTB_IDX+1:2];
        lk_tag      = i_lookup_pc[BTB_IDX+2 +: TAG_W];
        lk_pc_plus4 = i_lookup_pc + 32'd4;
        lk_cond     = btb_cond_mem[lk_bidx];
        lk_hit      = 1'b0;
        lk_taken    = 1'b0;
        if (ready) begin
            lk_hit   = btb_valid_q[lk_bidx] && (btb_tag_mem[lk_bidx] == lk_tag);
            lk_taken = lk_hit && (!lk_cond || pht_mem[lk_pidx][1]);
        end
    end

    assign o_ready       = ready;
    assign o_btb_hit     = lk_hit;
    assign o_pred_taken  = lk_taken;
    assign o_pred_target = lk_taken ? btb_tgt_mem[lk_bidx] : lk_pc_plus4;
    assign o_pred_ghr    = ghr_q;

    always_comb begin
        upd_en   = i_upd_valid && ready;
        upd_pidx = i_upd_pc[GBIT+1:2] ^ i_upd_ghr;
        upd_bidx = i_upd_pc[BTB_IDX+1:2];
        upd_tag  = i_upd_pc[BTB_IDX+2 +: TAG_W];
        upd_ctr  = pht_mem[upd_pidx];
        upd_ctr_next = upd_ctr;
        if (i_upd_taken) begin
            if (upd_ctr != 2'b11) begin
                upd_ctr_next = upd_ctr + 2'd1;
            end
        end else begin
            if (upd_ctr != 2'b00) begin
                upd_ctr_next = upd_ctr - 2'd1;
            end
        end
    end

    // Single PHT write port shared between the init sweep and EX training.
    always_comb begin
        pht_we    = 1'b0;
        pht_waddr = upd_pidx;
        pht_wdata = upd_ctr_next;
        if (state_q == ST_INIT) begin
            pht_we    = 1'b1;
            pht_waddr = init_ptr_q;
            pht_wdata = 2'b10;
        end else if (upd_en && i_upd_is_cond) begin
            pht_we = 1'b1;
        end
    end

    always_comb begin
        btb_we      = upd_en && i_upd_taken;
        btb_valid_d = btb_valid_q;
        if (btb_we) begin
            btb_valid_d[upd_bidx] = 1'b1;
        end
    end

    // A mispredict restore overrides any same-cycle speculative shift.
    always_comb begin
        ghr_d = ghr_q;
        if (i_lookup_valid && lk_hit && lk_cond) begin
            ghr_d = {lk_taken, ghr_q[GBIT-1:1]};
        end
        if (upd_en && i_upd_mispredict) begin
            ghr_d = i_upd_is_cond ? {i_upd_taken, i_upd_ghr[GBIT-1:1]} : i_upd_ghr;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_INIT;
            init_ptr_q  <= '0;
            ghr_q       <= '0;
            btb_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            init_ptr_q  <= init_ptr_d;
            ghr_q       <= ghr_d;
            btb_valid_q <= btb_valid_d;
        end
    end

    // Table payloads carry no reset; validity and the init sweep make them safe.
    always_ff @(posedge i_clk) begin
        if (pht_we) begin
            pht_mem[pht_waddr] <= pht_wdata;
        end
        if (btb_we) begin
            btb_tag_mem[upd_bidx]  <= upd_tag;
            btb_tgt_mem[upd_bidx]  <= i_upd_target;
            btb_cond_mem[upd_bidx] <= i_upd_is_cond;
        end
    end

`ifdef GSHARE_STATS_EN
    logic [31:0] lookup_cnt_q, lookup_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    always_comb begin
        lookup_cnt_d  = lookup_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (ready && i_lookup_valid) begin
            lookup_cnt_d = lookup_cnt_q + 32'd1;
        end
        if (upd_en && i_upd_mispredict) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lookup_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            lookup_cnt_q  <= lookup_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign o_lookup_cnt  = lookup_cnt_q;
    assign o_mispred_cnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Self-checking bench for gshare_btb_predictor: directed scenarios plus randomized traffic
// compared against a table-level reference model of the predictor.
module tb_gshare_btb_predictor;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_lookup_valid;
    logic [31:0] i_lookup_pc;
    logic        o_ready;
    logic        o_pred_taken;
    logic [31:0] o_pred_target;
    logic        o_btb_hit;
    logic [9:0]  o_pred_ghr;
    logic        i_upd_valid;
    logic [31:0] i_upd_pc;
    logic        i_upd_is_cond;
    logic        i_upd_taken;
    logic [31:0] i_upd_target;
    logic [9:0]  i_upd_ghr;
    logic        i_upd_mispredict;
`ifdef GSHARE_STATS_EN
    logic [31:0] o_lookup_cnt;
    logic [31:0] o_mispred_cnt;
`endif

    always #5 i_clk = ~i_clk;

    gshare_btb_predictor dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_lookup_valid   (i_lookup_valid),
        .i_lookup_pc      (i_lookup_pc),
        .o_ready          (o_ready),
        .o_pred_taken     (o_pred_taken),
        .o_pred_target    (o_pred_target),
        .o_btb_hit        (o_btb_hit),
        .o_pred_ghr       (o_pred_ghr),
        .i_upd_valid      (i_upd_valid),
        .i_upd_pc         (i_upd_pc),
        .i_upd_is_cond    (i_upd_is_cond),
        .i_upd_taken      (i_upd_taken),
        .i_upd_target     (i_upd_target),
        .i_upd_ghr        (i_upd_ghr),
        .i_upd_mispredict (i_upd_mispredict)
`ifdef GSHARE_STATS_EN
        ,
        .o_lookup_cnt     (o_lookup_cnt),
        .o_mispred_cnt    (o_mispred_cnt)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Reference model: plain tables indexed with arithmetic on the PC.
    int          m_pht   [1024];
    bit          m_bv    [64];
    int unsigned m_btag  [64];
    logic [31:0] m_btgt  [64];
    bit          m_bcond [64];
    logic [9:0]  m_ghr;
    bit          m_ready;
    int          m_init_cnt;
    logic [31:0] m_lcnt;
    logic [31:0] m_mcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_ghr = '0;
        m_ready = 1'b0;
        m_init_cnt = 0;
        m_lcnt = '0;
        m_mcnt = '0;
        for (int i = 0; i < 1024; i++) m_pht[i] = 2;
        for (int i = 0; i < 64; i++) m_bv[i] = 1'b0;
    endtask

    function automatic int bidx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic int pidx_of(input logic [31:0] pc, input logic [9:0] g);
        return int'(((pc >> 2) % 1024) ^ {22'd0, g});
    endfunction

    task automatic m_predict(input logic [31:0] pc, output bit hit, output bit taken,
                             output logic [31:0] tgt);
        int b;
        b = bidx_of(pc);
        hit = m_ready && m_bv[b] && (m_btag[b] == ((pc >> 8) % 4096));
        taken = hit && (!m_bcond[b] || (m_pht[pidx_of(pc, m_ghr)] >= 2));
        tgt = taken ? m_btgt[b] : pc + 32'd4;
    endtask

    // One clock: check outputs before the edge, advance the model at the edge.
    task automatic cyc(input string tag);
        bit h, t;
        logic [31:0] tg;
        logic [9:0] ng;
        int lb, ui, ub;
        #1;
        m_predict(i_lookup_pc, h, t, tg);
        chk({tag, "_ready"}, {31'd0, o_ready}, {31'd0, m_ready});
        chk({tag, "_hit"}, {31'd0, o_btb_hit}, {31'd0, h});
        chk({tag, "_taken"}, {31'd0, o_pred_taken}, {31'd0, t});
        chk({tag, "_target"}, o_pred_target, tg);
        chk({tag, "_ghr"}, {22'd0, o_pred_ghr}, {22'd0, m_ghr});
`ifdef GSHARE_STATS_EN
        chk({tag, "_lcnt"}, o_lookup_cnt, m_lcnt);
        chk({tag, "_mcnt"}, o_mispred_cnt, m_mcnt);
`endif
        @(posedge i_clk);
        ng = m_ghr;
        if (m_ready) begin
            lb = bidx_of(i_lookup_pc);
            if (i_lookup_valid) begin
                m_lcnt = m_lcnt + 1;
                if (h && m_bcond[lb]) ng = {t, m_ghr[9:1]};
            end
            if (i_upd_valid) begin
                ui = pidx_of(i_upd_pc, i_upd_ghr);
                ub = bidx_of(i_upd_pc);
                if (i_upd_is_cond) begin
                    if (i_upd_taken && m_pht[ui] < 3) m_pht[ui]++;
                    else if (!i_upd_taken && m_pht[ui] > 0) m_pht[ui]--;
                end
                if (i_upd_taken) begin
                    m_bv[ub] = 1'b1;
                    m_btag[ub] = (i_upd_pc >> 8) % 4096;
                    m_btgt[ub] = i_upd_target;
                    m_bcond[ub] = i_upd_is_cond;
                end
                if (i_upd_mispredict) begin
                    m_mcnt = m_mcnt + 1;
                    ng = i_upd_is_cond ? {i_upd_taken, i_upd_ghr[9:1]} : i_upd_ghr;
                end
            end
        end else begin
            m_init_cnt++;
            if (m_init_cnt == 1024) m_ready = 1'b1;
        end
        m_ghr = ng;
        @(negedge i_clk);
    endtask

    task automatic set_lk(input bit v, input logic [31:0] pc);
        i_lookup_valid = v;
        i_lookup_pc = pc;
    endtask

    task automatic set_up(input bit v, input logic [31:0] pc, input bit c, input bit tk,
                          input logic [31:0] tgt, input logic [9:0] g, input bit mis);
        i_upd_valid = v;
        i_upd_pc = pc;
        i_upd_is_cond = c;
        i_upd_taken = tk;
        i_upd_target = tgt;
        i_upd_ghr = g;
        i_upd_mispredict = mis;
    endtask

    task automatic random_phase(input int n);
        logic [31:0] pool [8];
        pool = '{32'h200, 32'h300, 32'h400, 32'h204, 32'h1204, 32'hFFFF_FFFC, 32'h208, 32'h2008};
        for (int i = 0; i < n; i++) begin
            set_lk($urandom_range(0, 3) != 0, pool[$urandom_range(0, 7)]);
            set_up($urandom_range(0, 1) == 1, pool[$urandom_range(0, 7)],
                   $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                   $urandom & 32'hFFFF_FFFC,
                   ($urandom_range(0, 1) == 1) ? m_ghr : 10'($urandom),
                   $urandom_range(0, 3) == 0);
            cyc("rand");
        end
        set_lk(1'b0, 32'h0);
        set_up(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 10'h0, 1'b0);
    endtask

    initial begin
        i_rst_n = 1'b0;
        set_lk(1'b1, 32'h100);
        set_up(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 10'h0, 1'b0);
        m_reset();
        #2;
        chk("rst_ready", {31'd0, o_ready}, 32'd0);
        chk("rst_taken", {31'd0, o_pred_taken}, 32'd0);
        chk("rst_target", o_pred_target, 32'h104);
        chk("rst_ghr", {22'd0, o_pred_ghr}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Init sweep; a taken update presented meanwhile must be ignored.
        set_up(1'b1, 32'h100, 1'b0, 1'b1, 32'h0999_0000, 10'h3FF, 1'b1);
        for (int i = 0; i < 1024; i++) cyc("init");
        set_up(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 10'h0, 1'b0);
        #2;
        chk("t1_ready", {31'd0, o_ready}, 32'd1);
        chk("t1_taken", {31'd0, o_pred_taken}, 32'd0);
        chk("t1_target", o_pred_target, 32'h104);
        chk("t1_hit", {31'd0, o_btb_hit}, 32'd0);
        chk("t1_ghr", {22'd0, o_pred_ghr}, 32'd0);
        cyc("t1");

        set_lk(1'b0, 32'h0);
        set_up(1'b1, 32'h200, 1'b1, 1'b1, 32'h180, 10'h0, 1'b0);
        cyc("t2u");
        set_up(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 10'h0, 1'b0);
        set_lk(1'b1, 32'h200);
        #2;
        chk("t2_hit", {31'd0, o_btb_hit}, 32'd1);
        chk("t2_taken", {31'd0, o_pred_taken}, 32'd1);
        chk("t2_target", o_pred_target, 32'h180);
        chk("t2_ghr", {22'd0, o_pred_ghr}, 32'd0);
        cyc("t2l");
        chk("t2_ghr_next", {22'd0, o_pred_ghr}, 32'h200);
        set_lk(1'b0, 32'h0);

        // Counter at 11: four not-taken trainings saturate it at 00; last one restores GHR to 0.
        for (int i = 0; i < 4; i++) begin
            set_up(1'b1, 32'h200, 1'b1, 1'b0, 32'h0, 10'h0, i == 3);
            cyc("t3u");
        end
        set_up(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 10'h0, 1'b0);
        set_lk(1'b1, 32'h200);
        #2;
        chk("t3_hit", {31'd0, o_btb_hit}, 32'd1);
        chk("t3_taken", {31'd0, o_pred_taken}, 32'd0);
        chk("t3_target", o_pred_target, 32'h204);
        cyc("t3l");

        set_lk(1'b1, 32'h200);
        set_up(1'b1, 32'h500, 1'b1, 1'b0, 32'h0, 10'h155, 1'b1);
        cyc("t4");
        chk("t4_ghr_restore", {22'd0, o_pred_ghr}, 32'h0AA);

        set_lk(1'b0, 32'h0);
        set_up(1'b1, 32'h300, 1'b0, 1'b1, 32'h400, 10'h0, 1'b0);
        cyc("t5u");
        set_up(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 10'h0, 1'b0);
        set_lk(1'b1, 32'h300);
        #2;
        chk("t5_hit", {31'd0, o_btb_hit}, 32'd1);
        chk("t5_taken", {31'd0, o_pred_taken}, 32'd1);
        chk("t5_target", o_pred_target, 32'h400);
        cyc("t5l");
        chk("t5_ghr_hold", {22'd0, o_pred_ghr}, 32'h0AA);
        set_lk(1'b1, 32'h400);
        #2;
        chk("t5_alias_hit", {31'd0, o_btb_hit}, 32'd0);
        chk("t5_alias_target", o_pred_target, 32'h404);
        cyc("t5a");
        set_lk(1'b1, 32'hFFFF_FFFC);
        #2;
        chk("wrap_target", o_pred_target, 32'h0);
        cyc("wrap");

        random_phase(1500);

        // Mid-run reset flushes everything and re-runs the init sweep.
        set_lk(1'b1, 32'h300);
        i_rst_n = 1'b0;
        m_reset();
        #2;
        chk("t6_ready", {31'd0, o_ready}, 32'd0);
        chk("t6_hit", {31'd0, o_btb_hit}, 32'd0);
        chk("t6_ghr", {22'd0, o_pred_ghr}, 32'd0);
`ifdef GSHARE_STATS_EN
        chk("t6_lcnt", o_lookup_cnt, 32'd0);
        chk("t6_mcnt", o_mispred_cnt, 32'd0);
`endif
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int i = 0; i < 1024; i++) cyc("reinit");
        #2;
        chk("t6_ready_again", {31'd0, o_ready}, 32'd1);
        chk("t6_hit_flushed", {31'd0, o_btb_hit}, 32'd0);
        cyc("t6l");

        random_phase(300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
